// File: rtl/exe_lane_dispatch_buffer_if.sv
// Dispatch-to-lane bundle: dispatch slots in, per-lane heads out,
// plus the backend stall and misroute status.
interface exe_lane_dispatch_buffer_if #(
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ISSUE_WIDTH     = 5,
    parameter int ISSUE_WIDTH_LOG = 3,
    parameter int LANE_DEPTH      = 8,
    parameter int PAYLOAD_W       = 32
);
    localparam int CNT_W = $clog2(LANE_DEPTH + 1);

    logic                                            recoverFlag_i;
    logic [ISSUE_WIDTH-1:0]                          execLaneActive_i;
    logic [DISPATCH_WIDTH-1:0]                       dispatchValid_i;
    logic [DISPATCH_WIDTH-1:0][ISSUE_WIDTH_LOG-1:0]  exePipes_i;
    logic [DISPATCH_WIDTH-1:0][PAYLOAD_W-1:0]        payload_i;
    logic                                            backEndReady_o;
    logic [ISSUE_WIDTH-1:0]                          laneValid_o;
    logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]           lanePayload_o;
    logic [ISSUE_WIDTH-1:0]                          laneReady_i;
    logic [ISSUE_WIDTH-1:0][CNT_W-1:0]               laneCount_o;
    logic                                            laneError_o;

    modport master (
        output recoverFlag_i, execLaneActive_i, dispatchValid_i,
        output exePipes_i, payload_i, laneReady_i,
        input  backEndReady_o, laneValid_o, lanePayload_o,
        input  laneCount_o, laneError_o
    );

    modport slave (
        input  recoverFlag_i, execLaneActive_i, dispatchValid_i,
        input  exePipes_i, payload_i, laneReady_i,
        output backEndReady_o, laneValid_o, lanePayload_o,
        output laneCount_o, laneError_o
    );
endinterface

// File: rtl/exe_lane_dispatch_buffer.sv
// Per-lane in-order receive FIFOs fed by a steered dispatch bundle,
// with a conservative whole-bundle stall and full flush on recovery.
module exe_lane_dispatch_buffer #(
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ISSUE_WIDTH     = 5,
    parameter int ISSUE_WIDTH_LOG = 3,
    parameter int LANE_DEPTH      = 8,
    parameter int PAYLOAD_W       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    exe_lane_dispatch_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(LANE_DEPTH);
    localparam int CNT_W = $clog2(LANE_DEPTH + 1);

    typedef logic [PAYLOAD_W-1:0] word_t;

    word_t storage_q [ISSUE_WIDTH][LANE_DEPTH];
    word_t storage_d [ISSUE_WIDTH][LANE_DEPTH];
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] head_q, head_d;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] tail_q, tail_d;
    logic [ISSUE_WIDTH-1:0][CNT_W-1:0] count_q, count_d;
    logic [ISSUE_WIDTH-1:0][CNT_W-1:0] push_n;
    logic                              err_q, err_d;

    logic [ISSUE_WIDTH-1:0] room;
    logic [ISSUE_WIDTH-1:0] valid;
    logic [ISSUE_WIDTH-1:0] pop;
    logic                   ready;
    logic                   accept;
    logic                   routed;
    logic [PTR_W-1:0]       wr_idx;

    // Stall uses registered counts only; same-cycle pops are ignored.
    always_comb begin
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            room[l]  = count_q[l] <= CNT_W'(LANE_DEPTH - DISPATCH_WIDTH);
            valid[l] = (count_q[l] != '0) & ~bus.recoverFlag_i;
            pop[l]   = valid[l] & bus.laneReady_i[l];
            bus.lanePayload_o[l] = storage_q[l][head_q[l]];
        end
    end

    assign ready  = &room;
    assign accept = ready & ~bus.recoverFlag_i;

    assign bus.backEndReady_o = ready;
    assign bus.laneValid_o    = valid;
    assign bus.laneCount_o    = count_q;
    assign bus.laneError_o    = err_q;

    always_comb begin
        storage_d = storage_q;
        err_d     = err_q;
        push_n    = '0;
        routed    = 1'b0;
        wr_idx    = '0;
        // Slot-major walk keeps same-lane slots in age order.
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            routed = 1'b0;
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (accept && bus.dispatchValid_i[s] &&
                    bus.exePipes_i[s] == ISSUE_WIDTH_LOG'(l) &&
                    bus.execLaneActive_i[l]) begin
                    wr_idx = tail_q[l] + push_n[l][PTR_W-1:0];
                    storage_d[l][wr_idx] = bus.payload_i[s];
                    push_n[l] = push_n[l] + CNT_W'(1);
                    routed = 1'b1;
                end
            end
            if (accept && bus.dispatchValid_i[s] && !routed)
                err_d = 1'b1;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (bus.recoverFlag_i) begin
                head_d[l]  = '0;
                tail_d[l]  = '0;
                count_d[l] = '0;
            end else begin
                head_d[l]  = head_q[l] + PTR_W'(pop[l]);
                tail_d[l]  = tail_q[l] + push_n[l][PTR_W-1:0];
                count_d[l] = count_q[l] + push_n[l] - CNT_W'(pop[l]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            storage_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            storage_q <= storage_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_exe_lane_dispatch_buffer.sv
// Scoreboard bench: per-lane expected queues filled on dispatch,
// popped and compared when a lane drains.
module tb_exe_lane_dispatch_buffer;
    localparam int DW = 4;
    localparam int IW = 5;
    localparam int LD = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   merr = 0;

    logic [31:0] sbq [IW][$];

    exe_lane_dispatch_buffer_if bus ();

    exe_lane_dispatch_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit model_ready();
        bit r = 1;
        for (int l = 0; l < IW; l++)
            if (sbq[l].size() > LD - DW) r = 0;
        return r;
    endfunction

    function automatic logic [IW-1:0] model_valid();
        logic [IW-1:0] v = '0;
        for (int l = 0; l < IW; l++)
            v[l] = (sbq[l].size() != 0) && !bus.recoverFlag_i;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.recoverFlag_i    = 1'b0;
        bus.execLaneActive_i = '1;
        bus.dispatchValid_i  = '0;
        bus.exePipes_i       = '0;
        bus.payload_i        = '0;
        bus.laneReady_i      = '0;
    endtask

    task automatic set_slot(input int s, input int lane, input logic [31:0] p);
        bus.dispatchValid_i[s] = 1'b1;
        bus.exePipes_i[s]      = 3'(lane);
        bus.payload_i[s]       = p;
    endtask

    // Advance the reference model with the inputs now on the bus, then clock.
    task automatic tick();
        bit acc;
        int lane;
        acc = model_ready() && !bus.recoverFlag_i;
        for (int l = 0; l < IW; l++)
            if (!bus.recoverFlag_i && bus.laneReady_i[l] && sbq[l].size() != 0)
                void'(sbq[l].pop_front());
        if (acc) begin
            for (int s = 0; s < DW; s++) begin
                if (bus.dispatchValid_i[s]) begin
                    lane = int'(bus.exePipes_i[s]);
                    if (lane < IW && bus.execLaneActive_i[lane])
                        sbq[lane].push_back(bus.payload_i[s]);
                    else
                        merr = 1;
                end
            end
        end
        if (bus.recoverFlag_i)
            for (int l = 0; l < IW; l++) sbq[l].delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.laneValid_o !== 5'b0) begin
            bad++; $display("FAIL rst_valid got=%b exp=0", bus.laneValid_o);
        end
        total++;
        if (bus.lanePayload_o !== '0) begin
            bad++; $display("FAIL rst_payload got=%h exp=0", bus.lanePayload_o);
        end
        total++;
        if (bus.laneCount_o !== '0) begin
            bad++; $display("FAIL rst_count got=%h exp=0", bus.laneCount_o);
        end
        total++;
        if (bus.laneError_o !== 1'b0) begin
            bad++; $display("FAIL rst_error got=%b exp=0", bus.laneError_o);
        end
        total++;
        if (bus.backEndReady_o !== 1'b1) begin
            bad++; $display("FAIL rst_ready got=%b exp=1", bus.backEndReady_o);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_drain(input string tag);
        int cyc = 0;
        idle_inputs();
        bus.laneReady_i = '1;
        while (cyc < 12 && model_valid() != '0) begin
            for (int l = 0; l < IW; l++) begin
                if (sbq[l].size() != 0) begin
                    total++;
                    if (bus.lanePayload_o[l] !== sbq[l][0]) begin
                        bad++;
                        $display("FAIL %s_drain lane%0d got=%h exp=%h",
                                 tag, l, bus.lanePayload_o[l], sbq[l][0]);
                    end
                end
            end
            tick();
            cyc++;
        end
        idle_inputs();
        total++;
        if (bus.laneCount_o !== '0 || model_valid() != '0) begin
            bad++; $display("FAIL %s_empty got=%h exp=0", tag, bus.laneCount_o);
        end
    endtask

    task automatic test_steer();
        idle_inputs();
        set_slot(0, 0, 32'hA000_0000);
        set_slot(1, 1, 32'hA000_0001);
        set_slot(2, 2, 32'hA000_0002);
        set_slot(3, 2, 32'hA000_0003);
        tick();
        idle_inputs();
        total++;
        if (bus.laneValid_o !== 5'b00111 || model_valid() !== 5'b00111) begin
            bad++; $display("FAIL steer_valid got=%b exp=00111", bus.laneValid_o);
        end
        total++;
        if (bus.lanePayload_o[2] !== 32'hA000_0002) begin
            bad++; $display("FAIL steer_head2 got=%h exp=a0000002", bus.lanePayload_o[2]);
        end
        total++;
        if (bus.laneCount_o[2] !== 4'd2) begin
            bad++; $display("FAIL steer_cnt2 got=%0d exp=2", bus.laneCount_o[2]);
        end
        bus.laneReady_i[2] = 1'b1;
        tick();
        idle_inputs();
        total++;
        if (bus.lanePayload_o[2] !== sbq[2][0] || sbq[2][0] !== 32'hA000_0003) begin
            bad++; $display("FAIL steer_next2 got=%h exp=a0000003", bus.lanePayload_o[2]);
        end
        total++;
        if (bus.laneCount_o[2] !== 4'd1) begin
            bad++; $display("FAIL steer_cnt2b got=%0d exp=1", bus.laneCount_o[2]);
        end
        total++;
        if (bus.laneError_o !== 1'b0) begin
            bad++; $display("FAIL steer_err got=%b exp=0", bus.laneError_o);
        end
        test_drain("steer");
    endtask

    task automatic test_stall();
        idle_inputs();
        for (int s = 0; s < DW; s++) set_slot(s, 3, 32'hB000_0000 + s);
        tick();
        idle_inputs();
        total++;
        if (bus.backEndReady_o !== 1'b1) begin
            bad++; $display("FAIL stall_ready4 got=%b exp=1", bus.backEndReady_o);
        end
        set_slot(0, 3, 32'hB000_0004);
        tick();
        idle_inputs();
        total++;
        if (bus.backEndReady_o !== 1'b0 || model_ready()) begin
            bad++; $display("FAIL stall_ready5 got=%b exp=0", bus.backEndReady_o);
        end
        set_slot(0, 0, 32'hBAD0_0000);
        set_slot(1, 3, 32'hBAD0_0001);
        tick();
        idle_inputs();
        total++;
        if (bus.laneCount_o[3] !== 4'd5 || bus.laneCount_o[0] !== 4'd0) begin
            bad++;
            $display("FAIL stall_hold got=%0d/%0d exp=5/0",
                     bus.laneCount_o[3], bus.laneCount_o[0]);
        end
        bus.laneReady_i[3] = 1'b1;
        total++;
        if (bus.backEndReady_o !== 1'b0 || bus.lanePayload_o[3] !== sbq[3][0]) begin
            bad++;
            $display("FAIL stall_pop got=%b/%h exp=0/%h",
                     bus.backEndReady_o, bus.lanePayload_o[3], sbq[3][0]);
        end
        tick();
        idle_inputs();
        total++;
        if (bus.backEndReady_o !== 1'b1 || bus.laneCount_o[3] !== 4'd4) begin
            bad++;
            $display("FAIL stall_lift got=%b/%0d exp=1/4",
                     bus.backEndReady_o, bus.laneCount_o[3]);
        end
        test_drain("stall");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 21; i++) begin
            idle_inputs();
            set_slot(0, 4, 32'hC000_0000 + i * 32'h11);
            bus.laneReady_i[4] = 1'b1;
            if (i > 0) begin
                total++;
                if (bus.laneCount_o[4] !== 4'd1 || bus.lanePayload_o[4] !== sbq[4][0]) begin
                    bad++;
                    $display("FAIL wrap_%0d got=%0d/%h exp=1/%h", i,
                             bus.laneCount_o[4], bus.lanePayload_o[4], sbq[4][0]);
                end
            end
            tick();
        end
        test_drain("wrap");
    endtask

    task automatic test_recover();
        idle_inputs();
        set_slot(0, 0, 32'hD000_0000);
        set_slot(1, 1, 32'hD000_0001);
        set_slot(2, 2, 32'hD000_0002);
        tick();
        idle_inputs();
        for (int s = 0; s < DW; s++) set_slot(s, s, 32'hDEAD_0000 + s);
        bus.recoverFlag_i = 1'b1;
        bus.laneReady_i   = '1;
        #1;
        total++;
        if (bus.laneValid_o !== 5'b0) begin
            bad++; $display("FAIL rec_valid got=%b exp=0", bus.laneValid_o);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (bus.laneCount_o !== '0 || model_valid() != '0) begin
            bad++; $display("FAIL rec_count got=%h exp=0", bus.laneCount_o);
        end
        total++;
        if (bus.laneValid_o !== 5'b0) begin
            bad++; $display("FAIL rec_lost got=%b exp=0", bus.laneValid_o);
        end
    endtask

    task automatic test_misroute();
        idle_inputs();
        set_slot(0, 6, 32'hE000_0000);
        set_slot(1, 4, 32'hE000_0001);
        set_slot(2, 0, 32'hE000_0002);
        set_slot(3, 1, 32'hE000_0003);
        bus.execLaneActive_i[4] = 1'b0;
        tick();
        idle_inputs();
        total++;
        if (bus.laneError_o !== merr || merr !== 1'b1) begin
            bad++; $display("FAIL mis_err got=%b exp=1", bus.laneError_o);
        end
        total++;
        if (bus.laneCount_o[0] !== 4'd1 || bus.laneCount_o[1] !== 4'd1 ||
            bus.laneCount_o[4] !== 4'd0) begin
            bad++; $display("FAIL mis_counts got=%h exp=lanes0,1=1 lane4=0", bus.laneCount_o);
        end
        total++;
        if (bus.lanePayload_o[0] !== 32'hE000_0002 || bus.lanePayload_o[1] !== 32'hE000_0003) begin
            bad++;
            $display("FAIL mis_heads got=%h/%h exp=e0000002/e0000003",
                     bus.lanePayload_o[0], bus.lanePayload_o[1]);
        end
        repeat (10) tick();
        total++;
        if (bus.laneError_o !== 1'b1) begin
            bad++; $display("FAIL mis_sticky got=%b exp=1", bus.laneError_o);
        end
        test_drain("mis");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_steer();
        test_stall();
        test_wrap();
        test_recover();
        test_misroute();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
